// File: rtl/inst_fetch_pkg.sv
// Shared fetch-side definitions: FSM state encodings, the nop word and
// the kseg0/kseg1 unmapped-segment constants.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP       = 32'h0000_0000;
    localparam logic [31:0] KSEG_UNMAP_MASK = 32'h1fff_ffff;
    localparam logic [1:0]  KSEG01_BITS     = 2'b10;

    function automatic logic is_kseg01(input logic [31:0] va);
        return va[31:30] == KSEG01_BITS;
    endfunction

endpackage

// File: rtl/fetch_xlate.sv
// Combinational virtual-to-physical translation; kseg0/kseg1 are unmapped
// windows onto the low 512 MB, everything else passes through unchanged.
module fetch_xlate
    import inst_fetch_pkg::*;
(
    input  logic [31:0] va,
    output logic [31:0] pa
);

    assign pa = is_kseg01(va) ? (va & KSEG_UNMAP_MASK) : va;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch responder: latches the PC, runs one req/ack bus read and
// returns the word with a one-cycle valid pulse. INST_FETCH_BUF_EN adds a
// one-entry fetch buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INSTR    = FETCH_NOP
) (
    input  logic         clk,
    input  logic         rest,
    input  logic [31:0]  pc_addr,
    input  logic         inv,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic         stall,
    output logic         adel,
    output logic         ibe,
    output logic [31:0]  bad_vaddr,
    output logic         bus_req,
    output logic [31:0]  bus_addr,
    input  logic         bus_ack,
    input  logic [31:0]  bus_rdata,
    input  logic         bus_err,
    output fetch_state_e state
);

    logic [31:0] pa;
    logic [31:0] wait_cnt;
    logic        buf_hit;

    fetch_xlate u_xlate (
        .va (pc_addr),
        .pa (pa)
    );

    assign stall = !instr_valid;

`ifdef INST_FETCH_BUF_EN
    logic        buf_valid;
    logic [31:0] buf_vaddr;
    logic [31:0] buf_data;

    // inv is checked here too so a same-cycle invalidate cannot be bypassed.
    assign buf_hit = buf_valid && !inv && (buf_vaddr == pc_addr);

    always_ff @(posedge clk) begin
        if (rest || inv) begin
            buf_valid <= 1'b0;
        end else if (state == FETCH_REQ && !bus_err && bus_ack) begin
            buf_valid <= 1'b1;
            buf_vaddr <= bad_vaddr;
            buf_data  <= bus_rdata;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign buf_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            state       <= FETCH_IDLE;
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            adel        <= 1'b0;
            ibe         <= 1'b0;
            bad_vaddr   <= '0;
            wait_cnt    <= '0;
        end else begin
            instr_valid <= 1'b0;
            adel        <= 1'b0;
            ibe         <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    bad_vaddr <= pc_addr;
                    if (pc_addr[1:0] != 2'b00) begin
                        state       <= FETCH_RESP;
                        adel        <= 1'b1;
                        instr_valid <= 1'b1;
                        instr       <= RESET_INSTR;
                    end else if (buf_hit) begin
                        state       <= FETCH_RESP;
                        instr_valid <= 1'b1;
`ifdef INST_FETCH_BUF_EN
                        instr       <= buf_data;
`endif
                    end else begin
                        state    <= FETCH_REQ;
                        bus_req  <= 1'b1;
                        bus_addr <= pa;
                    end
                end
                FETCH_REQ: begin
                    if (bus_err) begin
                        state       <= FETCH_RESP;
                        bus_req     <= 1'b0;
                        wait_cnt    <= '0;
                        ibe         <= 1'b1;
                        instr_valid <= 1'b1;
                        instr       <= RESET_INSTR;
                    end else if (bus_ack) begin
                        state       <= FETCH_RESP;
                        bus_req     <= 1'b0;
                        wait_cnt    <= '0;
                        instr_valid <= 1'b1;
                        instr       <= bus_rdata;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TIMEOUT_CYCLES - 1) begin
                        state       <= FETCH_RESP;
                        bus_req     <= 1'b0;
                        wait_cnt    <= '0;
                        ibe         <= 1'b1;
                        instr_valid <= 1'b1;
                        instr       <= RESET_INSTR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                FETCH_RESP: state <= FETCH_IDLE;
                default:    state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a driver issues fetches and pushes the
// expected response; a negedge monitor pops and compares on instr_valid.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int unsigned TO    = 6;
    localparam int          EXP_W = 66;

    logic         clk = 1'b0;
    logic         rest;
    logic [31:0]  pc_addr;
    logic         inv;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         stall;
    logic         adel;
    logic         ibe;
    logic [31:0]  bad_vaddr;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_ack;
    logic [31:0]  bus_rdata;
    logic         bus_err;
    fetch_state_e state;

    logic [EXP_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    inst_fetch #(.TIMEOUT_CYCLES(TO), .RESET_INSTR(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rest        (rest),
        .pc_addr     (pc_addr),
        .inv         (inv),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .adel        (adel),
        .ibe         (ibe),
        .bad_vaddr   (bad_vaddr),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: stall relation every cycle, response fields on each valid pulse.
    always @(negedge clk) begin
        chk("stall", {31'b0, stall}, {31'b0, !instr_valid});
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'b0, instr_valid}, 32'd0);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                chk("instr", instr, e[65:34]);
                chk("adel", {31'b0, adel}, {31'b0, e[33]});
                chk("ibe", {31'b0, ibe}, {31'b0, e[32]});
                chk("bad_vaddr", bad_vaddr, e[31:0]);
            end
        end else begin
            chk("idle_faults", {30'b0, adel, ibe}, 32'd0);
        end
    end

    // Issue one fetch from IDLE; returns in the following IDLE cycle.
    task automatic do_fetch(input logic [31:0] va, input logic [31:0] pa, input int waits,
                            input logic [31:0] rdata, input logic err,
                            input logic [31:0] e_instr, input logic e_adel, input logic e_ibe,
                            input int e_cycles, input int e_req, input logic do_inv,
                            input logic [31:0] va_change);
        int   cycles;
        int   req_cycles;
        logic addr_ok;
        logic done;
        exp_q.push_back({e_instr, e_adel, e_ibe, va});
        pc_addr    = va;
        cycles     = 1;
        req_cycles = 0;
        addr_ok    = 1'b1;
        done       = 1'b0;
        while (!done && cycles < 64) begin
            @(posedge clk); #1;
            cycles++;
            if (bus_req) begin
                req_cycles++;
                if (bus_addr !== pa) addr_ok = 1'b0;
                pc_addr   = va_change;
                bus_ack   = (req_cycles == waits + 1);
                bus_err   = err && (req_cycles == waits + 1);
                bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0;
                bus_err = 1'b0;
            end
            if (instr_valid) begin
                done = 1'b1;
                inv  = do_inv;
            end
        end
        chk("fetch_done", {31'b0, done}, 32'd1);
        chk("latency", cycles, e_cycles);
        chk("req_cycles", req_cycles, e_req);
        chk("bus_addr_stable", {31'b0, addr_ok}, 32'd1);
        @(posedge clk); #1;
        inv = 1'b0;
        chk("instr_hold", instr, e_instr);
        chk("back_to_idle", {30'b0, state}, {30'b0, FETCH_IDLE});
    endtask

    initial begin
        rest      = 1'b1;
        pc_addr   = '0;
        inv       = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        bus_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rest = 1'b0;
        chk("rst_state", {30'b0, state}, {30'b0, FETCH_IDLE});
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_bad_vaddr", bad_vaddr, 32'd0);

        // kseg0, ack in first REQ cycle
        do_fetch(32'h9fc0_0000, 32'h1fc0_0000, 0, 32'h2408_0001, 1'b0,
                 32'h2408_0001, 1'b0, 1'b0, 3, 1, 1'b0, 32'h9fc0_0000);
        // kseg1, 4 wait cycles, pc_addr wanders during REQ
        do_fetch(32'hbfc0_0004, 32'h1fc0_0004, 4, 32'h8c02_0000, 1'b0,
                 32'h8c02_0000, 1'b0, 1'b0, 7, 5, 1'b0, 32'h1234_5678);
        // misaligned: address error, no bus
        do_fetch(32'h9fc0_0002, 32'h0, 0, 32'h0, 1'b0,
                 32'h0000_0000, 1'b1, 1'b0, 2, 0, 1'b0, 32'h9fc0_0002);
        // bus_err together with bus_ack
        do_fetch(32'h0040_0000, 32'h0040_0000, 1, 32'hffff_ffff, 1'b1,
                 32'h0000_0000, 1'b0, 1'b1, 4, 2, 1'b0, 32'h0040_0000);
        // never acked: timeout after TO REQ cycles
        do_fetch(32'h8000_1000, 32'h0000_1000, 1000, 32'h0, 1'b0,
                 32'h0000_0000, 1'b0, 1'b1, TO + 2, TO, 1'b0, 32'h8000_1000);
        // kseg2 and useg pass through
        do_fetch(32'hc000_0000, 32'hc000_0000, 2, 32'h0123_4567, 1'b0,
                 32'h0123_4567, 1'b0, 1'b0, 5, 3, 1'b0, 32'hc000_0000);
        do_fetch(32'h0040_0010, 32'h0040_0010, 0, 32'h3c1d_8000, 1'b0,
                 32'h3c1d_8000, 1'b0, 1'b0, 3, 1, 1'b0, 32'h0040_0010);

        // reset during REQ, late ack in IDLE must be ignored
        pc_addr = 32'h0040_0020;
        @(posedge clk); #1;
        chk("abort_in_req", {31'b0, bus_req}, 32'd1);
        rest = 1'b1;
        @(posedge clk); #1;
        rest      = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hdead_beef;
        chk("abort_bus_req", {31'b0, bus_req}, 32'd0);
        chk("abort_state", {30'b0, state}, {30'b0, FETCH_IDLE});
        chk("abort_instr", instr, 32'd0);
        @(posedge clk); #1;
        chk("late_ack_state", {30'b0, state}, {30'b0, FETCH_REQ});
        chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        bus_ack = 1'b0;
        rest    = 1'b1;
        @(posedge clk); #1;
        rest = 1'b0;

        // repeated fetch, then invalidate and fetch again
        do_fetch(32'h9fc0_0000, 32'h1fc0_0000, 0, 32'h2408_0001, 1'b0,
                 32'h2408_0001, 1'b0, 1'b0, 3, 1, 1'b0, 32'h9fc0_0000);
`ifdef INST_FETCH_BUF_EN
        do_fetch(32'h9fc0_0000, 32'h1fc0_0000, 0, 32'h0, 1'b0,
                 32'h2408_0001, 1'b0, 1'b0, 2, 0, 1'b1, 32'h9fc0_0000);
`else
        do_fetch(32'h9fc0_0000, 32'h1fc0_0000, 0, 32'h2408_0009, 1'b0,
                 32'h2408_0009, 1'b0, 1'b0, 3, 1, 1'b1, 32'h9fc0_0000);
`endif
        do_fetch(32'h9fc0_0000, 32'h1fc0_0000, 0, 32'h2408_0002, 1'b0,
                 32'h2408_0002, 1'b0, 1'b0, 3, 1, 1'b0, 32'h9fc0_0000);

        rest = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
